instructnvm_arbiter: RTL and testbench

Shares one single-port instruction memory between the CoreABC instruction-fetch port and an APB slave port used for readback and patching of program words. Sits between the CoreABC sequencer and the instruction RAM/NVM macro. The APB data bus is narrower than the instruction word, so each APB access targets one byte lane; writes are performed as read-modify-write. Conflicts are resolved by alternating grant.

---
 rtl/instructnvm_arb_pkg.sv | 30 +++
 rtl/instructnvm_lane_mux.sv | 46 ++++
 rtl/instructnvm_arbiter.sv | 163 ++++++++++++++++
 tb/tb_instructnvm_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/instructnvm_arb_pkg.sv
// Shared state/grant types and lane sizing helpers for instructnvm_arbiter.
// The W_WR state exists only when INSTRUCTNVM_APB_WRITE_EN is defined.
package instructnvm_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        F_RD,
        F_CAP,
        A_RD,
        A_CAP,
`ifdef INSTRUCTNVM_APB_WRITE_EN
        W_WR,
`endif
        A_DONE
    } state_t;

    typedef enum logic {
        GNT_APB   = 1'b0,
        GNT_FETCH = 1'b1
    } grant_t;

    function automatic int lanes_f(input int iw, input int dw);
        return (iw + dw - 1) / dw;
    endfunction

    function automatic int lwidth_f(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/instructnvm_lane_mux.sv
// Byte-lane extract from an instruction word, plus lane merge for
// read-modify-write when INSTRUCTNVM_APB_WRITE_EN is defined.
module instructnvm_lane_mux
    import instructnvm_arb_pkg::*;
#(
    parameter  int IWWIDTH = 58,
    parameter  int DWIDTH  = 8,
    localparam int LANES   = lanes_f(IWWIDTH, DWIDTH),
    localparam int LWIDTH  = lwidth_f(LANES)
) (
    input  logic [IWWIDTH-1:0] word,
    input  logic [LWIDTH-1:0]  lane,
`ifdef INSTRUCTNVM_APB_WRITE_EN
    input  logic [DWIDTH-1:0]  wbyte,
    output logic [IWWIDTH-1:0] merged,
`endif
    output logic [DWIDTH-1:0]  rbyte
);

    localparam int PW = LANES * DWIDTH;

    // Top lane is zero-padded past IWWIDTH.
    logic [PW-1:0] padded;
    assign padded = PW'(word);

    always_comb begin
        rbyte = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane == LWIDTH'(i)) rbyte = padded[i*DWIDTH +: DWIDTH];
        end
    end

`ifdef INSTRUCTNVM_APB_WRITE_EN
    logic [PW-1:0] wide;

    always_comb begin
        wide = padded;
        for (int i = 0; i < LANES; i++) begin
            if (lane == LWIDTH'(i)) wide[i*DWIDTH +: DWIDTH] = wbyte;
        end
    end

    assign merged = IWWIDTH'(wide);
`endif

endmodule

// File: rtl/instructnvm_arbiter.sv
// Alternating-grant share of one instruction memory between CoreABC fetch
// and byte-lane APB access; INSTRUCTNVM_APB_WRITE_EN enables APB patching.
module instructnvm_arbiter
    import instructnvm_arb_pkg::*;
#(
    parameter int ICWIDTH = 8,
    parameter int IWWIDTH = 58,
    parameter int DWIDTH  = 8,
    parameter int AWIDTH  = 16
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic               START,
    input  logic [ICWIDTH-1:0] ADDRESS,
    output logic               STALL,
    output logic [IWWIDTH-1:0] INSTRUCTION,
    input  logic               PSEL,
    input  logic               PENABLE,
    input  logic               PWRITE,
    input  logic [AWIDTH-1:0]  PADDR,
    input  logic [DWIDTH-1:0]  PWDATA,
    output logic [DWIDTH-1:0]  PRDATA,
    output logic               PREADY,
    output logic               PSLVERR,
    output logic               MEM_EN,
    output logic               MEM_WE,
    output logic [ICWIDTH-1:0] MEM_ADDR,
    output logic [IWWIDTH-1:0] MEM_WDATA,
    input  logic [IWWIDTH-1:0] MEM_RDATA
);

    localparam int LANES  = lanes_f(IWWIDTH, DWIDTH);
    localparam int LWIDTH = lwidth_f(LANES);
    localparam int WA     = ICWIDTH + LWIDTH;

    state_t             state, nstate;
    grant_t             last_grant;
    logic               fetch_pending;
    logic [ICWIDTH-1:0] fetch_addr;
    logic               apb_wr, apb_err;
    logic               fetch_req, apb_req, apb_bad, apb_rej;
    logic               pick_fetch, in_wr;
    logic [LWIDTH-1:0]  lane;
    logic [ICWIDTH-1:0] word_addr;
    logic [DWIDTH-1:0]  rbyte;

    assign lane      = PADDR[LWIDTH-1:0];
    assign word_addr = PADDR[WA-1:LWIDTH];
    assign fetch_req = START | fetch_pending;
    assign apb_req   = PSEL & PENABLE & ~PREADY;
    assign apb_bad   = ((PADDR >> WA) != '0) || (int'(lane) >= LANES);
    assign STALL     = fetch_req;

    // last_grant only moves on a real conflict, so contention alternates.
    assign pick_fetch = fetch_req & (~apb_req | (last_grant == GNT_APB));

`ifdef INSTRUCTNVM_APB_WRITE_EN
    logic [IWWIDTH-1:0] word_reg;
    logic [IWWIDTH-1:0] merged;

    assign apb_rej   = apb_bad;
    assign in_wr     = (state == W_WR);
    assign MEM_WE    = in_wr;
    assign MEM_WDATA = in_wr ? word_reg : '0;

    instructnvm_lane_mux #(
        .IWWIDTH (IWWIDTH),
        .DWIDTH  (DWIDTH)
    ) u_mux (
        .word   (MEM_RDATA),
        .lane   (lane),
        .wbyte  (PWDATA),
        .merged (merged),
        .rbyte  (rbyte)
    );
`else
    logic unused_wdata;

    assign unused_wdata = ^PWDATA;
    assign apb_rej      = apb_bad | PWRITE;
    assign in_wr        = 1'b0;
    assign MEM_WE       = 1'b0;
    assign MEM_WDATA    = '0;

    instructnvm_lane_mux #(
        .IWWIDTH (IWWIDTH),
        .DWIDTH  (DWIDTH)
    ) u_mux (
        .word  (MEM_RDATA),
        .lane  (lane),
        .rbyte (rbyte)
    );
`endif

    assign MEM_EN  = (state == F_RD) | (state == A_RD) | in_wr;
    assign PREADY  = (state == A_DONE);
    assign PSLVERR = PREADY & apb_err;

    always_comb begin
        MEM_ADDR = '0;
        if (state == F_RD) MEM_ADDR = fetch_addr;
        else if ((state == A_RD) || in_wr) MEM_ADDR = word_addr;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE: begin
                if (pick_fetch) nstate = F_RD;
                else if (apb_req) nstate = apb_rej ? A_DONE : A_RD;
            end
            F_RD:   nstate = F_CAP;
            F_CAP:  nstate = IDLE;
            A_RD:   nstate = A_CAP;
`ifdef INSTRUCTNVM_APB_WRITE_EN
            A_CAP:  nstate = apb_wr ? W_WR : A_DONE;
            W_WR:   nstate = A_DONE;
`else
            A_CAP:  nstate = A_DONE;
`endif
            A_DONE: nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state         <= IDLE;
            last_grant    <= GNT_APB;
            fetch_pending <= 1'b0;
            fetch_addr    <= '0;
            apb_wr        <= 1'b0;
            apb_err       <= 1'b0;
            INSTRUCTION   <= '0;
            PRDATA        <= '0;
        end else begin
            state <= nstate;
            if (START && !fetch_pending) begin
                fetch_pending <= 1'b1;
                fetch_addr    <= ADDRESS;
            end else if (state == F_CAP) begin
                fetch_pending <= 1'b0;
            end
            if (state == IDLE && fetch_req && apb_req)
                last_grant <= pick_fetch ? GNT_FETCH : GNT_APB;
            if (state == IDLE && !pick_fetch && apb_req) begin
                apb_wr  <= PWRITE;
                apb_err <= apb_rej;
                if (apb_rej) PRDATA <= '0;
            end
            if (state == F_CAP) INSTRUCTION <= MEM_RDATA;
            if (state == A_CAP && !apb_wr) PRDATA <= rbyte;
        end
    end

`ifdef INSTRUCTNVM_APB_WRITE_EN
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) word_reg <= '0;
        else if (state == A_CAP && apb_wr) word_reg <= merged;
    end
`endif

endmodule

// File: tb/tb_instructnvm_arbiter.sv
// Randomized bench for instructnvm_arbiter against a transaction-level model
// (follows INSTRUCTNVM_APB_WRITE_EN the same way as the RTL).
module tb_instructnvm_arbiter;

    localparam int IWW = 58;
`ifdef INSTRUCTNVM_APB_WRITE_EN
    localparam bit WREN = 1'b1;
`else
    localparam bit WREN = 1'b0;
`endif

    logic           CLK = 1'b0;
    logic           RSTN, START, PSEL, PENABLE, PWRITE;
    logic [7:0]     ADDRESS, PWDATA, PRDATA;
    logic [15:0]    PADDR;
    logic           STALL, PREADY, PSLVERR, MEM_EN, MEM_WE;
    logic [IWW-1:0] INSTRUCTION, MEM_WDATA, MEM_RDATA;
    logic [7:0]     MEM_ADDR;

    always #5 CLK = ~CLK;

    instructnvm_arbiter dut (
        .CLK(CLK), .RSTN(RSTN), .START(START), .ADDRESS(ADDRESS),
        .STALL(STALL), .INSTRUCTION(INSTRUCTION),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR),
        .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
    );

    // memory macro stand-in, seeded from the model image
    logic [IWW-1:0] mem [256];
    logic [IWW-1:0] ref_mem [256];
    logic seed = 1'b0;
    int en_cnt = 0, we_cnt = 0;

    always @(posedge CLK) begin
        if (seed) begin
            for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
        end else if (MEM_EN) begin
            if (MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;
            else MEM_RDATA <= mem[MEM_ADDR];
        end
        if (MEM_EN) en_cnt <= en_cnt + 1;
        if (MEM_WE) we_cnt <= we_cnt + 1;
    end

    int n_tests = 0, n_fail = 0;
    bit last_f = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic xact(input bit df, input bit da, input logic [7:0] fa,
                        input bit pw, input logic [15:0] pa,
                        input logic [7:0] pd);
        int fl, al, own, fexp, aexp, e0, w0, w, l, xen, xwe;
        bit bad, ffirst;
        logic [7:0] rd, erd;
        logic er;
        logic [IWW-1:0] ins, fword;
        logic [63:0] wide;
        w = int'(pa[10:3]);
        l = int'(pa[2:0]);
        bad = (pa[15:11] != 5'd0) || (pw && !WREN);
        own = bad ? 1 : (pw ? 4 : 3);
        ffirst = df && (!da || !last_f);
        if (df && da) last_f = ffirst;
        fexp = ffirst ? 3 : own + 4;
        aexp = ffirst ? own + 3 : own;
        wide = 64'(ref_mem[w]);
        erd = wide[8*l +: 8];
        if (ffirst) fword = ref_mem[fa];
        if (da && pw && !bad) begin
            wide[8*l +: 8] = pd;
            ref_mem[w] = wide[IWW-1:0];
        end
        if (!ffirst) fword = ref_mem[fa];
        xen = (df ? 1 : 0) + ((da && !bad) ? (pw ? 2 : 1) : 0);
        xwe = (da && !bad && pw) ? 1 : 0;
        e0 = en_cnt;
        w0 = we_cnt;
        rd = 'x; er = 1'bx; ins = 'x;
        @(posedge CLK); #1;
        if (da) begin
            PSEL = 1; PENABLE = 0; PWRITE = pw; PADDR = pa; PWDATA = pd;
        end
        @(posedge CLK); #1;
        if (da) PENABLE = 1;
        if (df) begin START = 1; ADDRESS = fa; end
        fl = df ? -1 : 0;
        al = da ? -1 : 0;
        for (int n = 0; n < 40 && (fl < 0 || al < 0); n++) begin
            @(negedge CLK);
            if (fl < 0 && !STALL) begin fl = n; ins = INSTRUCTION; end
            if (al < 0 && PREADY) begin al = n; rd = PRDATA; er = PSLVERR; end
            @(posedge CLK); #1;
            START = 0;
            if (al >= 0) begin PSEL = 0; PENABLE = 0; end
        end
        START = 0; PSEL = 0; PENABLE = 0;
        if (df) begin
            chk("fetch_lat", 64'(fl), 64'(fexp));
            chk("instr", 64'(ins), 64'(fword));
        end
        if (da) begin
            chk("apb_lat", 64'(al), 64'(aexp));
            chk("pslverr", 64'(er), 64'(bad));
            if (bad || !pw) chk("prdata", 64'(rd), bad ? 64'd0 : 64'(erd));
            chk("mem_word", 64'(mem[w]), 64'(ref_mem[w]));
        end
        chk("mem_en_cnt", 64'(en_cnt - e0), 64'(xen));
        chk("mem_we_cnt", 64'(we_cnt - w0), 64'(xwe));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int mism, k;
        bit hit;
        logic [7:0] fa;
        logic [15:0] pa;
        for (int i = 0; i < 256; i++) ref_mem[i] = IWW'({$urandom(), $urandom()});
        ref_mem[8'h12] = 58'h3FF_0123_4567_89AB;
        ref_mem[8'h05] = 58'h3C0_0000_0000_0000;
        RSTN = 0; START = 1; ADDRESS = 8'h12;
        PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
        seed = 1;
        repeat (2) @(posedge CLK);
        #1 seed = 0;
        @(negedge CLK);
        chk("rst_stall", 64'(STALL), 64'd1);
        chk("rst_instr", 64'(INSTRUCTION), 64'd0);
        chk("rst_prdata", 64'(PRDATA), 64'd0);
        chk("rst_pready", 64'({PREADY, PSLVERR}), 64'd0);
        chk("rst_mem", 64'({MEM_EN, MEM_WE, MEM_ADDR}), 64'd0);
        chk("rst_wdata", 64'(MEM_WDATA), 64'd0);
        @(posedge CLK); #1 RSTN = 1;
        @(negedge CLK);
        chk("c0_stall", 64'(STALL), 64'd1);
        @(posedge CLK); #1 START = 0;
        @(negedge CLK);
        chk("c1_mem_en", 64'(MEM_EN), 64'd1);
        chk("c1_mem_addr", 64'(MEM_ADDR), 64'h12);
        @(negedge CLK);
        chk("c2_stall", 64'(STALL), 64'd1);
        @(negedge CLK);
        chk("c3_stall", 64'(STALL), 64'd0);
        chk("c3_instr", 64'(INSTRUCTION), 64'h3FF_0123_4567_89AB);

        xact(0, 1, 8'h00, 0, {5'd0, 8'h05, 3'd7}, 8'h00);
        xact(0, 1, 8'h00, 1, {5'd0, 8'h05, 3'd2}, 8'hA5);
        xact(0, 1, 8'h00, 0, {5'd0, 8'h05, 3'd2}, 8'h00);
        xact(1, 1, 8'h12, 0, {5'd0, 8'h05, 3'd7}, 8'h00);
        xact(1, 1, 8'h05, 0, {5'd0, 8'h12, 3'd0}, 8'h00);
        xact(0, 1, 8'h00, 0, {5'b10000, 8'h33, 3'd0}, 8'h00);

        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 3);
            fa = 8'($urandom_range(0, 255));
            pa = {5'd0, 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7))};
            if (k == 3) pa[15:11] = 5'($urandom_range(1, 31));
            xact(k != 1, k != 0, fa, 1'($urandom_range(0, 1)), pa,
                 8'($urandom_range(0, 255)));
        end

        // reset lands inside the memory write (or read when writes are off)
        @(posedge CLK); #1;
        PSEL = 1; PWRITE = WREN; PADDR = {5'd0, 8'd9, 3'd1};
        PWDATA = ~ref_mem[9][15:8];
        @(posedge CLK); #1 PENABLE = 1;
        hit = 0;
        for (int n = 0; n < 10 && !hit; n++) begin
            @(negedge CLK);
            hit = MEM_EN && (MEM_WE || !WREN);
        end
        chk("mid_hit", 64'(hit), 64'd1);
        RSTN = 0;
        #1;
        chk("mid_we_drop", 64'(MEM_WE), 64'd0);
        chk("mid_en_drop", 64'(MEM_EN), 64'd0);
        PSEL = 0; PENABLE = 0; PWRITE = 0;
        repeat (2) @(posedge CLK);
        #1 RSTN = 1;
        last_f = 0;
        chk("mid_mem_kept", 64'(mem[9]), 64'(ref_mem[9]));
        xact(1, 1, 8'h09, 0, {5'd0, 8'd9, 3'd1}, 8'h00);

        mism = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
        chk("mem_all", 64'(mism), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
